// File: rtl/npc_ctrl_pkg.sv
// Shared types for the NPC control unit: opcodes, immediate/ALU codes, FSM states, control bundle.
// NPC_CTRL_MULDIV_EN adds the MDWAIT state used while the multiply/divide unit runs.
package npc_ctrl_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  localparam logic [1:0] BSRC_RS2 = 2'b00;
  localparam logic [1:0] BSRC_IMM = 2'b01;
  localparam logic [1:0] BSRC_4   = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_U = 3'd2, IMM_S = 3'd3, IMM_B = 3'd4, IMM_J = 3'd5
  } imm_sel_e;

  // MDU codes sit at 5'b10_fff so funct3 maps straight onto them.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL    = 5'd2,  ALU_SLT   = 5'd3,
    ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA   = 5'd7,
    ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_COPYB  = 5'd10,
    ALU_MUL  = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV  = 5'd20, ALU_DIVU = 5'd21, ALU_REM    = 5'd22, ALU_REMU  = 5'd23
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0, ST_IWAIT = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3,
    ST_MWAIT = 3'd4, ST_WB    = 3'd5, ST_HALT = 3'd6
`ifdef NPC_CTRL_MULDIV_EN
    , ST_MDWAIT = 3'd7
`endif
  } state_e;

  typedef struct packed {
    imm_sel_e   imm;
    logic       asrc;
    logic [1:0] bsrc;
    alu_op_e    alu;
    logic       word;
    logic       branch;
    logic       load;
    logic       store;
    logic       wr_rd;
    logic       mdu;
    logic       ebreak;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/npc_ctrl_decode.sv
// Combinational decode of the latched instruction into the control bundle.
// NPC_CTRL_MULDIV_EN makes funct7=0000001 R-type encodings legal MDU operations.
module npc_ctrl_decode
  import npc_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]       ir,
  output logic [CTRL_W-1:0] ctl
);

  ctrl_t      c;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [6:0] sh_f7;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign ctl    = c;

  function automatic alu_op_e alu_base(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

  always_comb begin
    c = '0;
    // RV64 OP-IMM shifts have a 6-bit shamt, so funct7[0] belongs to the shift amount.
    sh_f7 = (XLEN == 64 && opcode == OPC_OPIMM) ? {f7[6:1], 1'b0} : f7;
    case (opcode)
      OPC_LUI:   begin c.imm = IMM_U; c.bsrc = BSRC_IMM; c.alu = ALU_COPYB; c.wr_rd = 1'b1; end
      OPC_AUIPC: begin c.imm = IMM_U; c.asrc = 1'b1; c.bsrc = BSRC_IMM; c.wr_rd = 1'b1; end
      OPC_JAL:   begin c.imm = IMM_J; c.asrc = 1'b1; c.bsrc = BSRC_4; c.wr_rd = 1'b1; end
      OPC_JALR: begin
        c.imm = IMM_I; c.asrc = 1'b1; c.bsrc = BSRC_4; c.wr_rd = 1'b1;
        c.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        c.imm = IMM_B; c.branch = 1'b1;
        case (f3[2:1])
          2'b00:   c.alu = ALU_SUB;
          2'b10:   c.alu = ALU_SLT;
          2'b11:   c.alu = ALU_SLTU;
          default: c.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        c.imm = IMM_I; c.bsrc = BSRC_IMM; c.load = 1'b1; c.wr_rd = 1'b1;
        c.illegal = (f3 == 3'b111) || (XLEN != 64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        c.imm = IMM_S; c.bsrc = BSRC_IMM; c.store = 1'b1;
        c.illegal = f3[2] || (XLEN != 64 && f3 == 3'b011);
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        c.imm = IMM_I; c.bsrc = BSRC_IMM; c.wr_rd = 1'b1;
        c.word = (opcode == OPC_OPIMM32);
        c.alu  = alu_base(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)      c.illegal = (sh_f7 != 7'b0000000);
        else if (f3 == 3'b101) c.illegal = (sh_f7 != 7'b0000000) && (sh_f7 != 7'b0100000);
        else                   c.illegal = c.word && (f3 != 3'b000);
      end
      OPC_OP, OPC_OP32: begin
        c.bsrc  = BSRC_RS2; c.wr_rd = 1'b1;
        c.word  = (opcode == OPC_OP32);
        case (f7)
          7'b0000000: begin
            c.alu     = alu_base(f3, 1'b0);
            c.illegal = c.word && !(f3 inside {3'b000, 3'b001, 3'b101});
          end
          7'b0100000: begin
            c.alu     = alu_base(f3, 1'b1);
            c.illegal = !(f3 inside {3'b000, 3'b101});
          end
`ifdef NPC_CTRL_MULDIV_EN
          7'b0000001: begin
            c.mdu     = 1'b1;
            c.alu     = alu_op_e'({2'b10, f3});
            c.illegal = c.word && (f3 inside {3'b001, 3'b010, 3'b011});
          end
`endif
          default: c.illegal = 1'b1;
        endcase
      end
      OPC_FENCE:  c.illegal = (f3 > 3'b001);
      OPC_SYSTEM: begin
        if (ir == INST_EBREAK) c.ebreak  = 1'b1;
        else                   c.illegal = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    if (XLEN != 64 && c.word) c.illegal = 1'b1;
    // An illegal word drives no datapath controls.
    if (c.illegal) begin
      c = '0;
      c.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle NPC control FSM: fetch/exec/mem/writeback sequencing, IR, watchdog, sticky halt flags.
// NPC_CTRL_MULDIV_EN enables MDU dispatch (mdu_start pulse, MDWAIT until mdu_done); ALU_SEL_W must then be 5.
module npc_ctrl_fsm
  import npc_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ALU_SEL_W = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 inst_req_valid,
  input  logic                 inst_req_ready,
  input  logic                 inst_rsp_valid,
  input  logic [31:0]          inst_rsp_data,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  output logic                 mdu_start,
  input  logic                 mdu_done,
  output logic [2:0]           op_imm,
  output logic                 op_alu_asrc,
  output logic [1:0]           op_alu_bsrc,
  output logic [ALU_SEL_W-1:0] op_alu_sel,
  output logic                 alu_word,
  output logic                 branch,
  output logic                 load,
  output logic                 en_wmem,
  output logic                 en_wreg,
  output logic                 pc_we,
  output logic                 halt,
  output logic                 illegal,
  output logic                 timeout
);

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  state_e      state, state_nxt;
  ctrl_t       ctl;
  logic [31:0] ir;
  logic [31:0] wd_cnt;
  logic        run;
  logic        ir_load, set_ill, set_to, wait_st, wd_hit;
  logic        halt_q, illegal_q, timeout_q;

  npc_ctrl_decode #(.XLEN(XLEN)) u_decode (
    .ir  (ir),
    .ctl (ctl)
  );

  assign op_imm      = ctl.imm;
  assign op_alu_asrc = ctl.asrc;
  assign op_alu_bsrc = ctl.bsrc;
  assign op_alu_sel  = ALU_SEL_W'(ctl.alu);
  assign alu_word    = ctl.word;
  assign branch      = ctl.branch;
  assign load        = ctl.load;
  assign en_wmem     = mem_req_valid & ctl.store;
  assign halt        = halt_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;

`ifndef NPC_CTRL_MULDIV_EN
  logic unused_mdu_done;
  assign unused_mdu_done = mdu_done;
  assign mdu_start       = 1'b0;
`endif

  always_comb begin
    wait_st = state inside {ST_FETCH, ST_IWAIT, ST_MEM, ST_MWAIT};
`ifdef NPC_CTRL_MULDIV_EN
    if (state == ST_MDWAIT) wait_st = 1'b1;
`endif
    wd_hit = (TIMEOUT != 0) && run && wait_st && (wd_cnt == WD_LAST);
  end

  always_comb begin
    state_nxt      = state;
    inst_req_valid = 1'b0;
    mem_req_valid  = 1'b0;
    pc_we          = 1'b0;
    en_wreg        = 1'b0;
    ir_load        = 1'b0;
    set_ill        = 1'b0;
    set_to         = 1'b0;
`ifdef NPC_CTRL_MULDIV_EN
    mdu_start      = 1'b0;
`endif
    case (state)
      // run keeps the fetch request low until the first cycle after rst is released.
      ST_FETCH: if (run) begin
        inst_req_valid = 1'b1;
        if (inst_req_ready) state_nxt = ST_IWAIT;
      end
      ST_IWAIT: if (inst_rsp_valid) begin
        ir_load   = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (ctl.ebreak)                state_nxt = ST_HALT;
        else if (ctl.illegal)          begin set_ill = 1'b1; state_nxt = ST_HALT; end
        else if (ctl.load | ctl.store) state_nxt = ST_MEM;
`ifdef NPC_CTRL_MULDIV_EN
        else if (ctl.mdu)              begin mdu_start = 1'b1; state_nxt = ST_MDWAIT; end
`endif
        else                           state_nxt = ST_WB;
      end
      ST_MEM: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = ST_MWAIT;
      end
      ST_MWAIT: if (mem_rsp_valid) state_nxt = ST_WB;
`ifdef NPC_CTRL_MULDIV_EN
      ST_MDWAIT: if (mdu_done) state_nxt = ST_WB;
`endif
      ST_WB: begin
        pc_we     = 1'b1;
        en_wreg   = ctl.wr_rd && (ir[11:7] != 5'd0);
        state_nxt = ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
    if (wd_hit && state_nxt == state) begin
      set_to    = 1'b1;
      state_nxt = ST_HALT;
    end
  end

  // State, IR, watchdog and sticky flags all advance on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      run       <= 1'b0;
      ir        <= '0;
      wd_cnt    <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      run    <= 1'b1;
      if (ir_load) ir <= inst_rsp_data;
      wd_cnt <= (run && wait_st && state_nxt == state) ? wd_cnt + 32'd1 : 32'd0;
      if (state_nxt == ST_HALT) halt_q    <= 1'b1;
      if (set_ill)              illegal_q <= 1'b1;
      if (set_to)               timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Directed bench for npc_ctrl_fsm: instruction sequence on a mostly zero-wait bus, halts, reset and watchdog.
module tb_npc_ctrl_fsm;

`ifdef NPC_CTRL_MULDIV_EN
  localparam int ASW = 5;
`else
  localparam int ASW = 4;
`endif

  localparam logic [31:0] I_ADDI   = 32'h00500093;
  localparam logic [31:0] I_LW     = 32'h0000A103;
  localparam logic [31:0] I_SW     = 32'h0020A223;
  localparam logic [31:0] I_BLT    = 32'h0020C463;
  localparam logic [31:0] I_SUB    = 32'h402081B3;
  localparam logic [31:0] I_MUL    = 32'h022081B3;
  localparam logic [31:0] I_EBREAK = 32'h00100073;

  logic           clk = 1'b0;
  logic           rst;
  logic           inst_req_valid, inst_req_ready, inst_rsp_valid;
  logic [31:0]    inst_rsp_data;
  logic           mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic           mdu_start, mdu_done;
  logic [2:0]     op_imm;
  logic           op_alu_asrc;
  logic [1:0]     op_alu_bsrc;
  logic [ASW-1:0] op_alu_sel;
  logic           alu_word, branch, load, en_wmem, en_wreg, pc_we;
  logic           halt, illegal, timeout;

  int nvec = 0;
  int nerr = 0;

  npc_ctrl_fsm #(.XLEN(32), .ALU_SEL_W(ASW), .TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req_valid (inst_req_valid),
    .inst_req_ready (inst_req_ready),
    .inst_rsp_valid (inst_rsp_valid),
    .inst_rsp_data  (inst_rsp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mdu_start      (mdu_start),
    .mdu_done       (mdu_done),
    .op_imm         (op_imm),
    .op_alu_asrc    (op_alu_asrc),
    .op_alu_bsrc    (op_alu_bsrc),
    .op_alu_sel     (op_alu_sel),
    .alu_word       (alu_word),
    .branch         (branch),
    .load           (load),
    .en_wmem        (en_wmem),
    .en_wreg        (en_wreg),
    .pc_we          (pc_we),
    .halt           (halt),
    .illegal        (illegal),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; inst_req_ready = 1'b0; inst_rsp_valid = 1'b0; inst_rsp_data = 32'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mdu_done = 1'b0;
    tick(); tick();
    // reset state: every output low
    chk("rst_ireq", inst_req_valid, 0);
    chk("rst_mreq", mem_req_valid, 0);
    chk("rst_pcwe", pc_we, 0);
    chk("rst_wreg", en_wreg, 0);
    chk("rst_halt", {halt, illegal, timeout}, 0);
    chk("rst_imm", op_imm, 0);
    chk("rst_sel", op_alu_sel, 0);
    chk("rst_cls", {branch, load, en_wmem, mdu_start, alu_word, op_alu_asrc, op_alu_bsrc}, 0);

    // addi x1,x0,5 on a zero-wait bus
    inst_req_ready = 1'b1; inst_rsp_valid = 1'b1; inst_rsp_data = I_ADDI;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; rst = 1'b0;
    tick(); chk("addi_c1_ireq", inst_req_valid, 1);
    tick(); chk("addi_c2_ireq", inst_req_valid, 0);
    tick(); chk("addi_c3_imm", op_imm, 1);
    chk("addi_c3_bsrc", op_alu_bsrc, 2'b01);
    chk("addi_c3_sel", op_alu_sel, 0);
    chk("addi_c3_pcwe", pc_we, 0);
    tick(); chk("addi_c4_pcwe", pc_we, 1);
    chk("addi_c4_wreg", en_wreg, 1);
    inst_rsp_data = I_LW;
    tick(); chk("addi_c5_wreg", en_wreg, 0);
    chk("addi_c5_ireq", inst_req_valid, 1);
    chk("addi_c5_imm_stable", op_imm, 1);

    // lw x2,0(x1) with mem_req_ready low for three cycles
    tick(); mem_req_ready = 1'b0;
    tick(); chk("lw_exec_load", load, 1);
    chk("lw_exec_mreq", mem_req_valid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_hold", mem_req_valid, 1);
      chk("lw_mem_wmem", en_wmem, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    chk("lw_mem_accept", mem_req_valid, 1);
    tick(); chk("lw_mwait_mreq", mem_req_valid, 0);
    chk("lw_mwait_pcwe", pc_we, 0);
    tick(); chk("lw_wb_wreg", en_wreg, 1);
    chk("lw_wb_pcwe", pc_we, 1);
    inst_rsp_data = I_SW;

    // sw x2,4(x1)
    tick(); tick();
    tick(); chk("sw_exec_imm", op_imm, 3);
    chk("sw_exec_load", load, 0);
    tick(); chk("sw_mem_mreq", mem_req_valid, 1);
    chk("sw_mem_wmem", en_wmem, 1);
    tick(); chk("sw_mwait_wmem", en_wmem, 0);
    tick(); chk("sw_wb_pcwe", pc_we, 1);
    chk("sw_wb_wreg", en_wreg, 0);
    inst_rsp_data = I_BLT;

    // blt x1,x2,8
    tick(); tick();
    tick(); chk("blt_branch", branch, 1);
    chk("blt_sel", op_alu_sel, 3);
    chk("blt_imm", op_imm, 4);
    chk("blt_bsrc", op_alu_bsrc, 0);
    tick(); chk("blt_wb_pcwe", pc_we, 1);
    chk("blt_wb_wreg", en_wreg, 0);
    inst_rsp_data = I_SUB;

    // sub x3,x1,x2
    tick(); tick();
    tick(); chk("sub_sel", op_alu_sel, 1);
    chk("sub_bsrc", op_alu_bsrc, 0);
    tick(); chk("sub_wb_wreg", en_wreg, 1);
    inst_rsp_data = I_MUL;

    // mul x3,x1,x2
    tick(); tick();
    tick();
`ifdef NPC_CTRL_MULDIV_EN
    chk("mul_start", mdu_start, 1);
    chk("mul_sel", op_alu_sel, 16);
    tick(); chk("mul_start_pulse", mdu_start, 0);
    chk("mul_wait_pcwe", pc_we, 0);
    tick(); chk("mul_wait2_pcwe", pc_we, 0);
    mdu_done = 1'b1;
    tick(); mdu_done = 1'b0;
    chk("mul_wb_pcwe", pc_we, 1);
    chk("mul_wb_wreg", en_wreg, 1);
    chk("mul_illegal", illegal, 0);
`else
    chk("mul_exec_start", mdu_start, 0);
    chk("mul_exec_halt", halt, 0);
    tick(); chk("mul_illegal", illegal, 1);
    chk("mul_halt", halt, 1);
    chk("mul_halt_ireq", inst_req_valid, 0);
    tick(); tick(); chk("mul_halt_stays", {halt, inst_req_valid}, 2'b10);
`endif

    // ebreak halts one cycle after EXEC and only rst clears it
    rst = 1'b1; inst_rsp_data = I_EBREAK;
    tick(); chk("rst2_flags", {halt, illegal, timeout}, 0);
    chk("rst2_ireq", inst_req_valid, 0);
    rst = 1'b0;
    tick(); chk("eb_c1_ireq", inst_req_valid, 1);
    tick(); tick(); chk("eb_exec_halt", halt, 0);
    tick(); chk("eb_halt", halt, 1);
    chk("eb_illegal", illegal, 0);
    for (int i = 0; i < 4; i++) begin
      chk("eb_no_fetch", inst_req_valid, 0);
      tick();
    end
    chk("eb_sticky", halt, 1);

    // reset asserted while a load sits in MEM
    rst = 1'b1; inst_rsp_data = I_LW; mem_req_ready = 1'b0;
    tick(); chk("rst3_halt", halt, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    tick(); chk("rmem_mreq", mem_req_valid, 1);
    rst = 1'b1;
    tick(); chk("rmem_mreq_drop", mem_req_valid, 0);
    chk("rmem_ireq", inst_req_valid, 0);
    rst = 1'b0;
    tick(); chk("rmem_fetch", inst_req_valid, 1);

    // watchdog: IWAIT never answered
    inst_rsp_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("wd_iwait_no_to", timeout, 0);
      tick();
    end
    chk("wd_timeout", timeout, 1);
    chk("wd_halt", halt, 1);
    chk("wd_illegal", illegal, 0);
    chk("wd_ireq", inst_req_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
